// File: rtl/attack_resolver.sv
`default_nettype none
// ============================================================================
// Module   : attack_resolver
// Purpose  : Resolves one attack at a time. It rolls an 8-bit LFSR, decides
//            hit or miss against the attack's accuracy, and subtracts the
//            damage from the defender's HP, saturating at 0. It tracks both
//            players' HP and declares a winner when either HP reaches 0.
// Ports    : clk_i        rising-edge clock
//            reset_i      asynchronous active-high reset
//            start_i      one-cycle attack request (honoured only in IDLE)
//            attacker_i   0: P1 attacks P2, 1: P2 attacks P1
//            dmg_i        damage (4b), accu_i accuracy (4b, 15 = always hits)
//            new_game_i   synchronous battle restart, overrides start_i
//            busy_o       attack in flight (ROLL, APPLY)
//            done_o       one-cycle pulse when the result is valid
//            hit_o/crit_o result of the last attack, held until next done_o
//            hp1_o/hp2_o  player hit points
//            game_over_o  high once either HP reaches 0
//            winner_o     0: P1 won, 1: P2 won (valid with game_over_o)
// Options  : define ATTACK_RESOLVER_CRIT_EN to enable critical hits
//            (roll[7:4] == 4'hF on a hit doubles the damage).
// Revision : 1.0 - initial release
// ============================================================================
module attack_resolver #(
  parameter int         HP_W      = 6,
  parameter int         HP_MAX    = 40,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            attacker_i,
  input  logic [3:0]      dmg_i,
  input  logic [3:0]      accu_i,
  input  logic            new_game_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            hit_o,
  output logic            crit_o,
  output logic [HP_W-1:0] hp1_o,
  output logic [HP_W-1:0] hp2_o,
  output logic            game_over_o,
  output logic            winner_o
);

  // Subtraction width: wide enough for both the HP value and a doubled damage.
  localparam int             SUB_W    = (HP_W > 5) ? HP_W : 5;
  localparam logic [HP_W-1:0] C_HP_MAX = HP_W'(HP_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROLL  = 3'd1,
    S_APPLY = 3'd2,
    S_DONE  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t          state_q;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      roll_q;
  logic            attacker_q;
  logic [3:0]      dmg_q;
  logic [3:0]      accu_q;
  logic [HP_W-1:0] hp1_q, hp2_q;
  logic            busy_q, done_q, hit_q, crit_q, game_over_q, winner_q;

  logic            hit_n;
  logic            crit_n;
  logic [4:0]      dmg_eff;
  logic [HP_W-1:0] def_hp;
  logic [HP_W-1:0] hp_after;
  logic [SUB_W-1:0] def_ext, dmg_ext;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1. Free-running in every state, including
  // across new_game; only reset reloads the seed.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  // Resolution datapath, evaluated against the latched attack and the roll.
  always_comb begin
    hit_n   = (roll_q[3:0] <= accu_q);
`ifdef ATTACK_RESOLVER_CRIT_EN
    crit_n  = hit_n && (roll_q[7:4] == 4'hF);
    dmg_eff = crit_n ? {dmg_q, 1'b0} : {1'b0, dmg_q};
`else
    crit_n  = 1'b0;
    dmg_eff = {1'b0, dmg_q};
`endif
    def_hp  = attacker_q ? hp1_q : hp2_q;
    def_ext = SUB_W'(def_hp);
    dmg_ext = SUB_W'(dmg_eff);
    // Clamp at 0; the result never exceeds def_hp, so truncation is safe.
    if (def_ext > dmg_ext) hp_after = HP_W'(def_ext - dmg_ext);
    else                   hp_after = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      roll_q      <= '0;
      attacker_q  <= 1'b0;
      dmg_q       <= '0;
      accu_q      <= '0;
      hp1_q       <= C_HP_MAX;
      hp2_q       <= C_HP_MAX;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      crit_q      <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else if (new_game_i) begin
      state_q     <= S_IDLE;
      hp1_q       <= C_HP_MAX;
      hp2_q       <= C_HP_MAX;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      crit_q      <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      // done is a single-cycle pulse raised only on the APPLY->DONE step.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            attacker_q <= attacker_i;
            dmg_q      <= dmg_i;
            accu_q     <= accu_i;
            busy_q     <= 1'b1;
            state_q    <= S_ROLL;
          end
        end
        S_ROLL: begin
          roll_q  <= lfsr_q;
          state_q <= S_APPLY;
        end
        S_APPLY: begin
          if (hit_n) begin
            if (attacker_q) hp1_q <= hp_after;
            else            hp2_q <= hp_after;
          end
          hit_q   <= hit_n;
          crit_q  <= crit_n;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          // HP was written in APPLY, so def_hp already holds the result.
          if (def_hp == '0) begin
            game_over_q <= 1'b1;
            winner_q    <= attacker_q;
            state_q     <= S_OVER;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_OVER: begin
          state_q <= S_OVER;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign hit_o       = hit_q;
  assign crit_o      = crit_q;
  assign hp1_o       = hp1_q;
  assign hp2_o       = hp2_q;
  assign game_over_o = game_over_q;
  assign winner_o    = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_attack_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_attack_resolver
// Purpose  : Self-checking bench for attack_resolver. A behavioural model
//            tracks both HP values, the game state and the LFSR sequence;
//            attacks are driven as directed steps and as randomized runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_attack_resolver;

  localparam int HP_W   = 6;
  localparam int HP_MAX = 40;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            attacker;
  logic [3:0]      dmg;
  logic [3:0]      accu;
  logic            new_game;
  logic            busy, done, hit, crit, game_over, winner;
  logic [HP_W-1:0] hp1, hp2;

  attack_resolver #(
    .HP_W      (HP_W),
    .HP_MAX    (HP_MAX),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .attacker_i  (attacker),
    .dmg_i       (dmg),
    .accu_i      (accu),
    .new_game_i  (new_game),
    .busy_o      (busy),
    .done_o      (done),
    .hit_o       (hit),
    .crit_o      (crit),
    .hp1_o       (hp1),
    .hp2_o       (hp2),
    .game_over_o (game_over),
    .winner_o    (winner)
  );

  always #5 clk = ~clk;

  // LFSR model: full 255-state sequence from the seed plus a cycle index.
  logic [7:0] seq [255];
  int         idx;
  always @(posedge clk or posedge reset) begin
    if (reset) idx <= 0;
    else       idx <= idx + 1;
  end

  // Game model
  int m_hp1, m_hp2;
  bit m_over, m_win, m_hit, m_crit;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_hp1 = HP_MAX; m_hp2 = HP_MAX;
    m_over = 0; m_win = 0; m_hit = 0; m_crit = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".hp1"}, hp1, m_hp1);
    check({tag, ".hp2"}, hp2, m_hp2);
    check({tag, ".game_over"}, game_over, m_over);
    if (m_over) check({tag, ".winner"}, winner, m_win);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
    check_state("new_game");
    check("new_game.hit", hit, 0);
    check("new_game.done", done, 0);
  endtask

  // Full attack from IDLE: start in cycle N, result in N+3, back in N+4.
  task automatic attack(input bit att, input logic [3:0] d, input logic [3:0] a);
    logic [7:0] roll;
    int         eff, dh;
    start = 1'b1; attacker = att; dmg = d; accu = a;
    tick();
    // Scramble inputs: the in-flight attack must use the latched values.
    start = 1'b0; attacker = 1'($urandom); dmg = 4'($urandom); accu = 4'($urandom);
    roll = seq[idx % 255];
    check("roll.busy", busy, 1);
    check("roll.done", done, 0);
    tick();
    attacker = 1'($urandom); dmg = 4'($urandom); accu = 4'($urandom);
    check("apply.busy", busy, 1);
    check("apply.done", done, 0);
    m_hit = (int'(roll) % 16) <= int'(a);
`ifdef ATTACK_RESOLVER_CRIT_EN
    m_crit = m_hit && (int'(roll) / 16 == 15);
`else
    m_crit = 0;
`endif
    eff = m_crit ? 2 * int'(d) : int'(d);
    if (m_hit) begin
      dh = att ? m_hp1 : m_hp2;
      dh = (dh > eff) ? dh - eff : 0;
      if (att) m_hp1 = dh; else m_hp2 = dh;
    end
    tick();
    check("done.done", done, 1);
    check("done.busy", busy, 0);
    check("done.hit", hit, m_hit);
    check("done.crit", crit, m_crit);
    check("done.hp1", hp1, m_hp1);
    check("done.hp2", hp2, m_hp2);
    if ((att ? m_hp1 : m_hp2) == 0) begin
      m_over = 1; m_win = att;
    end
    tick();
    check("after.done", done, 0);
    check_state("after");
  endtask

  initial begin
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < 255; i++) begin
      seq[i] = v;
      // Feedback is the parity of taps 8,6,5,4 (bit mask 0xB8).
      v = {v[6:0], ^(v & 8'hB8)};
    end

    reset = 1'b1; start = 1'b0; attacker = 1'b0; dmg = '0; accu = '0; new_game = 1'b0;
    model_reset();
    tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.hit", hit, 0);
    check("rst.crit", crit, 0);
    check_state("rst");
    tick();
    reset = 1'b0;

    // Idle: LFSR follows the polynomial sequence starting at A5
    check("lfsr.seed", dut.lfsr_q, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle.lfsr", dut.lfsr_q, seq[idx % 255]);
      check("idle.busy", busy, 0);
      check("idle.done", done, 0);
      check_state("idle");
    end

    // Single sure hit: hp2 40 -> 37
    attack(1'b0, 4'd3, 4'd15);
    check("first.hp2", hp2, 37);

    // Three heavy hits on player 1: 25, 10, then clamp to 0
    attack(1'b1, 4'd15, 4'd15);
    attack(1'b1, 4'd15, 4'd15);
    attack(1'b1, 4'd15, 4'd15);
    check("kill.hp1", hp1, 0);
    check("kill.over", game_over, 1);
    check("kill.winner", winner, 1);

    // start ignored in OVER
    start = 1'b1; attacker = 1'b1; dmg = 4'd5; accu = 4'd15;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("over.done", done, 0);
      check("over.busy", busy, 0);
      check_state("over");
    end
    start = 1'b0;
    pulse_new_game();

    // new_game wins over start in IDLE
    new_game = 1'b1; start = 1'b1;
    tick();
    new_game = 1'b0; start = 1'b0;
    check("prio.busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("prio.done", done, 0);
      check_state("prio");
    end

    // start held high: one accepted attack every 4 cycles
    start = 1'b1; attacker = 1'b0; dmg = 4'd3; accu = 4'd15;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("held.done", done, (k % 4) == 3);
      check("held.busy", busy, (k % 4) == 1 || (k % 4) == 2);
      if ((k % 4) == 3) check("held.hp2", hp2, HP_MAX - 3 * (k / 4 + 1));
    end
    start = 1'b0;
    m_hp2 = HP_MAX - 9; m_hit = 1;
    tick();
    check("held.idle", busy, 0);
    check_state("held");

    // Random attacks with accuracy 0, then with random accuracy
    for (int i = 0; i < 96; i++) begin
      if (m_over) pulse_new_game();
      attack(1'($urandom), 4'($urandom_range(0, 15)),
             (i < 64) ? 4'd0 : 4'($urandom_range(0, 15)));
    end
    if (m_over) pulse_new_game();

    // Reset during APPLY aborts without a done pulse
    start = 1'b1; attacker = 1'b0; dmg = 4'd5; accu = 4'd15;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    model_reset();
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check_state("abort");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort.nodone", done, 0);
      check_state("abort.after");
    end

    // Defeat player 2, then new_game from OVER and a normal attack
    attack(1'b0, 4'd15, 4'd15);
    attack(1'b0, 4'd15, 4'd15);
    attack(1'b0, 4'd15, 4'd15);
    check("p1win.over", game_over, 1);
    check("p1win.winner", winner, 0);
    pulse_new_game();
    check("ng.winner", winner, 0);
    attack(1'b1, 4'd7, 4'd15);
    check("ng.hp1", hp1, HP_MAX - 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
